traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Two-road intersection sequencer (road A = main, road B = side) driven by the system 1 s tick pulse_1s. Steps a six-phase Moore FSM, with per-phase durations loaded into an internal loadable seconds back-counter. Provides one-hot lamp drives for both roads and the remaining-seconds value for the countdown display. Adds side-road demand extension of A-green and a night flashing-yellow mode.

Parameters:
W, 4, width of the seconds counter and the remain output
T_AG, 10, A-green duration in pulses (1..2^W-1)
T_AY, 3, A-yellow duration
T_BG, 7, B-green duration
T_BY, 3, B-yellow duration
T_AR, 2, all-red clearance duration (both clearance phases)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pulse_1s  in  1  one-clk-wide tick, once per second
car_b  in  1  side-road demand (level); 0 = no vehicle waiting on B
night_mode  in  1  request flashing mode (level)
light_a  out  3  {red,yellow,green} for road A
light_b  out  3  {red,yellow,green} for road B
remain  out  W  seconds left in current phase (display)
phase  out  3  current state code (debug/display)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Assertion at any time, including mid-phase, forces reset values immediately.
- Reset values: phase=A_GREEN, remain=T_AG, blink=0, light_a=001, light_b=100.
- States, with codes and lamps:
  - A_GREEN (0): A=001, B=100
  - A_YELLOW (1): A=010, B=100
  - ALL_RED_1 (2): A=100, B=100
  - B_GREEN (3): A=100, B=001
  - B_YELLOW (4): A=100, B=010
  - ALL_RED_2 (5): A=100, B=100
  - FLASH (6): A=B={0,blink,0}
- Lamps are pure decode of the registered state: Moore, no input-to-output path.
- Nothing changes on cycles without pulse_1s.
- On pulse_1s with remain>1: remain <= remain-1, state held.
- Phase boundary = pulse_1s with remain==1. The next state is loaded with its duration in the same cycle. Result: each phase lasts exactly T pulses, and remain shows T..1.
- Boundary transitions, in priority order:
  1. night_mode=1 at any boundary: go to FLASH, remain<=0, blink<=1.
  2. A_GREEN with car_b=0: stay in A_GREEN, remain<=T_AG (extension, repeats indefinitely).
  3. Normal sequence: A_GREEN→A_YELLOW→ALL_RED_1→B_GREEN→B_YELLOW→ALL_RED_2→A_GREEN.
- night_mode and car_b are sampled only at boundaries. Changes mid-phase have no effect.
- FLASH:
  - On each pulse_1s, blink toggles.
  - If night_mode=0 at a pulse: go to ALL_RED_2, remain<=T_AR, blink<=0. That pulse does not toggle blink.
  - remain=0 throughout FLASH.
- Unused state code 7: go to A_GREEN, remain=T_AG on the next clk.
- remain never underflows. The value 0 appears only in FLASH.
- Durations are W bits. A parameter value of 0 or ≥2^W is illegal; the design carries an elaboration check.

Decomposition:
- Shared package traffic_pkg:
  - state enum/localparams with codes 0..6
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000
- One sub-module, phase_backcounter: W-bit down-counter with inputs pulse_1s, load, load_val and outputs count and last (count==1).
- The FSM in traffic_phase_ctrl drives load/load_val from the next-state duration.

Test Plan:
1. Reset, then car_b=1, night_mode=0, pulse_1s every 4 clk.
   - Phase sequence 0,1,2,3,4,5,0 with lengths 10,3,2,7,3,2 pulses.
   - remain counts 10..1 in A_GREEN.
   - light_a=001/light_b=100 until the 10th pulse, then light_a=010.
2. car_b=0 throughout.
   - A_GREEN persists across 3 boundaries; remain reloads to 10 each time.
   - Raise car_b=1 mid-phase: A_YELLOW follows at the next boundary only.
3. night_mode=1 raised during B_GREEN at remain=5.
   - No change until B_GREEN ends; then FLASH, remain=0.
   - light_a=light_b=010, then 000, alternating each pulse.
   - Drop night_mode: next pulse gives ALL_RED_2 (remain=2), then A_GREEN.
4. Hold pulse_1s low 100 clk in A_YELLOW → state, remain and lamps constant.
5. Assert rst_n=0 asynchronously mid-B_YELLOW, off a clk edge → outputs at reset values immediately; restart gives a full 10-pulse A_GREEN.
6. pulse_1s and night_mode rising on the same clk at an A_GREEN boundary with car_b=0 → FLASH wins over extension.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and the fixed phase order for the intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALL_RED_1 = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALL_RED_2 = 3'd5,
    FLASH     = 3'd6
  } state_t;

  // Lamp bits are {red,yellow,green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic state_t seq_next(input state_t s);
    case (s)
      A_GREEN:   return A_YELLOW;
      A_YELLOW:  return ALL_RED_1;
      ALL_RED_1: return B_GREEN;
      B_GREEN:   return B_YELLOW;
      B_YELLOW:  return ALL_RED_2;
      default:   return A_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/phase_backcounter.sv
// Loadable seconds down-counter; load wins over the tick and the count parks at 1 (or 0) without wrapping.
// last flags the final second of a phase so the FSM can reload in the same cycle.
module phase_backcounter #(
  parameter int          W       = 4,
  parameter int unsigned RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_1s,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (pulse_1s && count > W'(1))
      count <= count - W'(1);
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Six-phase two-road sequencer with side-road demand extension and night flashing mode.
// Lamps are a Moore decode of the registered state; the counter reloads on the boundary tick itself.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int          W    = 4,
  parameter int unsigned T_AG = 10,
  parameter int unsigned T_AY = 3,
  parameter int unsigned T_BG = 7,
  parameter int unsigned T_BY = 3,
  parameter int unsigned T_AR = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_1s,
  input  logic         car_b,
  input  logic         night_mode,
  output logic [2:0]   light_a,
  output logic [2:0]   light_b,
  output logic [W-1:0] remain,
  output logic [2:0]   phase
);

  localparam int unsigned MAX_DUR = (1 << W) - 1;

  if (T_AG < 1 || T_AG > MAX_DUR || T_AY < 1 || T_AY > MAX_DUR ||
      T_BG < 1 || T_BG > MAX_DUR || T_BY < 1 || T_BY > MAX_DUR ||
      T_AR < 1 || T_AR > MAX_DUR) begin : g_bad_duration
    $error("traffic_phase_ctrl: every phase duration must lie in 1..2^W-1");
  end

  state_t       state, nxt_state;
  logic         blink, nxt_blink;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         last;

  function automatic logic [W-1:0] dur(input state_t s);
    case (s)
      A_YELLOW:             return W'(T_AY);
      ALL_RED_1, ALL_RED_2: return W'(T_AR);
      B_GREEN:              return W'(T_BG);
      B_YELLOW:             return W'(T_BY);
      default:              return W'(T_AG);
    endcase
  endfunction

  phase_backcounter #(.W(W), .RST_VAL(T_AG)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_1s (pulse_1s),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .last     (last)
  );

  always_comb begin
    nxt_state = state;
    nxt_blink = blink;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      FLASH: begin
        if (pulse_1s) begin
          if (!night_mode) begin
            nxt_state = ALL_RED_2;
            nxt_blink = 1'b0;
            load      = 1'b1;
            load_val  = W'(T_AR);
          end else begin
            nxt_blink = ~blink;
          end
        end
      end
      A_GREEN, A_YELLOW, ALL_RED_1, B_GREEN, B_YELLOW, ALL_RED_2: begin
        if (pulse_1s && last) begin
          load = 1'b1;
          if (night_mode) begin
            nxt_state = FLASH;
            nxt_blink = 1'b1;
            load_val  = '0;
          end else if (state == A_GREEN && !car_b) begin
            load_val = W'(T_AG);
          end else begin
            nxt_state = seq_next(state);
            load_val  = dur(seq_next(state));
          end
        end
      end
      default: begin
        // Illegal code 7 recovers without waiting for a tick
        nxt_state = A_GREEN;
        nxt_blink = 1'b0;
        load      = 1'b1;
        load_val  = W'(T_AG);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= A_GREEN;
      blink <= 1'b0;
    end else begin
      state <= nxt_state;
      blink <= nxt_blink;
    end
  end

  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    case (state)
      A_GREEN:  light_a = LAMP_GRN;
      A_YELLOW: light_a = LAMP_YEL;
      B_GREEN:  light_b = LAMP_GRN;
      B_YELLOW: light_b = LAMP_YEL;
      FLASH: begin
        light_a = blink ? LAMP_YEL : LAMP_OFF;
        light_b = blink ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign remain = count;
  assign phase  = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: a reference model queues expected outputs per driven cycle, compared one clock later.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_1s = 1'b0;
  logic       car_b = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] light_a, light_b, phase;
  logic [3:0] remain;

  int total = 0;
  int bad = 0;

  typedef struct {
    int ph;
    int rem;
    int la;
    int lb;
  } exp_t;
  exp_t sb[$];

  int m_ph, m_rem, m_blink;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .W(4), .T_AG(10), .T_AY(3), .T_BG(7), .T_BY(3), .T_AR(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_1s   (pulse_1s),
    .car_b      (car_b),
    .night_mode (night_mode),
    .light_a    (light_a),
    .light_b    (light_b),
    .remain     (remain),
    .phase      (phase)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      0:       return 10;
      1:       return 3;
      2:       return 2;
      3:       return 7;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int lamp_a(input int p, input int bl);
    case (p)
      0:       return 1;
      1:       return 2;
      6:       return bl ? 2 : 0;
      default: return 4;
    endcase
  endfunction

  function automatic int lamp_b(input int p, input int bl);
    case (p)
      3:       return 1;
      4:       return 2;
      6:       return bl ? 2 : 0;
      default: return 4;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_rem = 10;
    m_blink = 0;
  endtask

  task automatic model_pulse();
    if (m_ph == 6) begin
      if (!night_mode) begin
        m_ph = 5; m_rem = 2; m_blink = 0;
      end else begin
        m_blink = 1 - m_blink;
      end
    end else if (m_rem == 1) begin
      if (night_mode) begin
        m_ph = 6; m_rem = 0; m_blink = 1;
      end else if (m_ph == 0 && !car_b) begin
        m_rem = 10;
      end else begin
        m_ph = (m_ph + 1) % 6;
        m_rem = dur_of(m_ph);
      end
    end else begin
      m_rem = m_rem - 1;
    end
  endtask

  // One clock: drive at negedge, queue the model's prediction, compare at the next negedge
  task automatic step(input bit p, input string tag);
    exp_t e;
    pulse_1s = p;
    if (p) model_pulse();
    e.ph = m_ph; e.rem = m_rem;
    e.la = lamp_a(m_ph, m_blink); e.lb = lamp_b(m_ph, m_blink);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    pulse_1s = 1'b0;
    e = sb.pop_front();
    check({tag, ".phase"},   phase,   e.ph);
    check({tag, ".remain"},  remain,  e.rem);
    check({tag, ".light_a"}, light_a, e.la);
    check({tag, ".light_b"}, light_b, e.lb);
  endtask

  task automatic sec(input string tag);
    step(1'b1, tag);
    repeat (3) step(1'b0, tag);
  endtask

  task automatic secs(input int n, input string tag);
    repeat (n) sec(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.phase", phase, 0);
    check("rst.remain", remain, 10);
    check("rst.light_a", light_a, 1);
    check("rst.light_b", light_b, 4);
    rst_n = 1'b1;

    // Full cycle with demand present
    car_b = 1'b1;
    secs(9, "t1");
    check("t1.ag_last_rem", remain, 1);
    check("t1.ag_last_la", light_a, 1);
    sec("t1");
    check("t1.ay_phase", phase, 1);
    check("t1.ay_la", light_a, 2);
    check("t1.ay_rem", remain, 3);
    secs(17, "t1");
    check("t1.wrap_phase", phase, 0);
    check("t1.wrap_rem", remain, 10);

    // No demand: A-green extends
    car_b = 1'b0;
    secs(30, "t2");
    check("t2.ext_phase", phase, 0);
    check("t2.ext_rem", remain, 10);
    secs(4, "t2");
    car_b = 1'b1;
    secs(6, "t2");
    check("t2.ay_phase", phase, 1);

    // Night mode raised mid B-green
    secs(7, "t3");
    check("t3.bg_phase", phase, 3);
    check("t3.bg_rem", remain, 5);
    night_mode = 1'b1;
    secs(4, "t3");
    check("t3.bg_hold", phase, 3);
    sec("t3");
    check("t3.flash_phase", phase, 6);
    check("t3.flash_rem", remain, 0);
    check("t3.flash_on", light_a, 2);
    sec("t3");
    check("t3.flash_off", light_b, 0);
    sec("t3");
    night_mode = 1'b0;
    sec("t3");
    check("t3.ar2_phase", phase, 5);
    check("t3.ar2_rem", remain, 2);
    secs(2, "t3");
    check("t3.ag_phase", phase, 0);

    // No ticks: everything frozen in A-yellow
    secs(11, "t4");
    repeat (100) step(1'b0, "t4");
    check("t4.phase", phase, 1);
    check("t4.remain", remain, 2);

    // Async reset mid B-yellow, off the clock edge
    secs(12, "t5");
    check("t5.by_phase", phase, 4);
    check("t5.by_rem", remain, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.arst_phase", phase, 0);
    check("t5.arst_remain", remain, 10);
    check("t5.arst_la", light_a, 1);
    check("t5.arst_lb", light_b, 4);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    secs(9, "t5");
    check("t5.ag_still", phase, 0);
    sec("t5");
    check("t5.ay_phase", phase, 1);

    // Night mode beats extension at the same boundary
    secs(17, "t6");
    car_b = 1'b0;
    secs(9, "t6");
    check("t6.ag_rem", remain, 1);
    night_mode = 1'b1;
    sec("t6");
    check("t6.flash_phase", phase, 6);
    check("t6.flash_rem", remain, 0);
    night_mode = 1'b0;
    sec("t6");
    check("t6.ar2_phase", phase, 5);

    check("sb.empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
